// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

  // Architectural read latency of the memory macro.
  localparam int unsigned mem_read_latency = 2;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_DATA  = 2'd2
  } arb_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_READ_FETCH = 2'd1,
    ARB_READ_DATA  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_latency_counter.sv
// Load/decrement counter that times the memory read latency; zero flags expiry.
module mem_arb_latency_counter #(
  parameter int unsigned Width = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with zero-cycle grant.
// Optional MEM_ARB_ROUND_ROBIN_EN alternates grants on contention.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned READ_LATENCY = mem_read_latency
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_done,
  output logic [XLEN-1:0]   if_r_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic [XLEN-1:0]   ls_w_data,
  input  logic [XLEN/8-1:0] ls_w_mask,
  output logic              ls_done,
  output logic [XLEN-1:0]   ls_r_data,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_w_data,
  output logic              mem_w_en,
  output logic [XLEN/8-1:0] mem_w_mask,
  input  logic [XLEN-1:0]   mem_r_data,
  output arb_owner_t        owner
);

  localparam int unsigned CntW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  if (READ_LATENCY < 1) begin : g_latency_check
    $error("mem_port_arbiter: READ_LATENCY must be at least 1");
  end

  arb_state_t state_q, state_d;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic       pick_ls;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when load/store took the most recent grant; reset favours ls first.
  logic last_ls_q, last_ls_d;

  assign pick_ls = ls_req & (~if_req | ~last_ls_q);

  always_comb begin
    last_ls_d = last_ls_q;
    if (reset_n && (state_q == ARB_IDLE) && (ls_req || if_req)) begin
      last_ls_d = pick_ls;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_ls_q <= 1'b0;
    end else begin
      last_ls_q <= last_ls_d;
    end
  end
`else
  assign pick_ls = ls_req;
`endif

  // No arbitration while reset is held, so outputs read as idle immediately.
  always_comb begin
    state_d    = state_q;
    mem_addr   = '0;
    mem_w_data = '0;
    mem_w_mask = '0;
    mem_w_en   = 1'b0;
    owner      = OWNER_NONE;
    if_done    = 1'b0;
    ls_done    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_ls) begin
            owner    = OWNER_DATA;
            mem_addr = ls_addr;
            if (ls_we) begin
              mem_w_en   = 1'b1;
              mem_w_data = ls_w_data;
              mem_w_mask = ls_w_mask;
              ls_done    = 1'b1;
            end else begin
              state_d  = ARB_READ_DATA;
              cnt_load = 1'b1;
            end
          end else if (if_req) begin
            owner    = OWNER_FETCH;
            mem_addr = if_addr;
            state_d  = ARB_READ_FETCH;
            cnt_load = 1'b1;
          end
        end
        ARB_READ_FETCH: begin
          owner    = OWNER_FETCH;
          mem_addr = if_addr;
          if (cnt_zero) begin
            if_done = 1'b1;
            state_d = ARB_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ARB_READ_DATA: begin
          owner    = OWNER_DATA;
          mem_addr = ls_addr;
          if (cnt_zero) begin
            ls_done = 1'b1;
            state_d = ARB_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  mem_arb_latency_counter #(
    .Width (CntW)
  ) u_latency_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_value (CntW'(READ_LATENCY - 1)),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  assign if_r_data = mem_r_data;
  assign ls_r_data = mem_r_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned L = mem_read_latency;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_r_data;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_w_data = '0;
  logic [3:0]  ls_w_mask = '0;
  logic        ls_done;
  logic [31:0] ls_r_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic        mem_w_en;
  logic [3:0]  mem_w_mask;
  logic [31:0] mem_r_data;
  arb_owner_t  owner;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .XLEN         (32),
    .READ_LATENCY (L)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_done    (if_done),
    .if_r_data  (if_r_data),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_w_data  (ls_w_data),
    .ls_w_mask  (ls_w_mask),
    .ls_done    (ls_done),
    .ls_r_data  (ls_r_data),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_w_en   (mem_w_en),
    .mem_w_mask (mem_w_mask),
    .mem_r_data (mem_r_data),
    .owner      (owner)
  );

  // Memory macro: returns data for the address presented L cycles earlier.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
  endfunction

  logic [31:0] ahist [L];
  always @(posedge clock) begin
    ahist[0] <= mem_addr;
    for (int i = 1; i < L; i++) ahist[i] <= ahist[i-1];
  end
  assign mem_r_data = pat(ahist[L-1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a read occupies the port from its grant cycle g to g+L.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_owner = 0;
  logic [31:0] m_addr = '0;
  int          m_done_cyc = 0;
  bit          m_last_ls = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int winner();
    if (ls_req && if_req) return (Rr && m_last_ls) ? 1 : 2;
    if (ls_req) return 2;
    if (if_req) return 1;
    return 0;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy    <= 1'b0;
      m_last_ls <= 1'b0;
    end else if (m_busy) begin
      if (cyc == m_done_cyc) m_busy <= 1'b0;
    end else if (winner() != 0) begin
      m_last_ls <= (winner() == 2);
      if (winner() == 1 || !ls_we) begin
        m_busy     <= 1'b1;
        m_owner    <= winner();
        m_addr     <= (winner() == 1) ? if_addr : ls_addr;
        m_done_cyc <= cyc + L;
      end
    end
  end

  always @(negedge clock) begin
    logic [31:0] ea;
    logic [31:0] eaddr_rd;
    int          eo;
    bit          ewe, eifd, elsd;
    ea = '0; eaddr_rd = '0; eo = 0; ewe = 1'b0; eifd = 1'b0; elsd = 1'b0;
    if (reset_n) begin
      if (m_busy) begin
        eo = m_owner;
        ea = m_addr;
        eaddr_rd = m_addr;
        if (cyc == m_done_cyc) begin
          if (m_owner == 1) eifd = 1'b1;
          else elsd = 1'b1;
        end
      end else if (winner() == 1) begin
        eo = 1;
        ea = if_addr;
      end else if (winner() == 2) begin
        eo = 2;
        ea = ls_addr;
        if (ls_we) begin
          ewe  = 1'b1;
          elsd = 1'b1;
        end
      end
    end
    chk("model owner", 32'(owner), 32'(eo));
    chk("model mem_addr", mem_addr, ea);
    chk("model mem_w_en", 32'(mem_w_en), 32'(ewe));
    chk("model if_done", 32'(if_done), 32'(eifd));
    chk("model ls_done", 32'(ls_done), 32'(elsd));
    if (ewe) begin
      chk("model mem_w_data", mem_w_data, ls_w_data);
      chk("model mem_w_mask", 32'(mem_w_mask), 32'(ls_w_mask));
    end
    if (eifd) chk("model if_r_data", if_r_data, pat(eaddr_rd));
    if (elsd && !ewe) chk("model ls_r_data", ls_r_data, pat(eaddr_rd));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  int exp_grant [4];

  initial begin
    // Reset state
    repeat (2) step();
    mid();
    chk("reset owner", 32'(owner), 32'(OWNER_NONE));
    chk("reset mem_w_en", 32'(mem_w_en), 0);
    chk("reset if_done", 32'(if_done), 0);
    chk("reset mem_addr", mem_addr, 0);
    step();
    reset_n = 1'b1;
    step();

    // Fetch read alone
    if_req = 1'b1; if_addr = 32'h100;
    mid(); chk("fetch c0 addr", mem_addr, 32'h100); chk("fetch c0 done", 32'(if_done), 0);
    step();
    mid(); chk("fetch c1 addr", mem_addr, 32'h100); chk("fetch c1 done", 32'(if_done), 0);
    step();
    mid(); chk("fetch c2 done", 32'(if_done), 1); chk("fetch c2 data", if_r_data, 32'h13);
    chk("fetch c2 addr", mem_addr, 32'h100);
    step();
    if_req = 1'b0;
    mid(); chk("fetch c3 owner", 32'(owner), 32'(OWNER_NONE));
    step();

    // Contention: load beats fetch, fetch follows once the port frees up
    if_req = 1'b1; if_addr = 32'h104; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000;
    mid(); chk("cont c0 owner", 32'(owner), 32'(OWNER_DATA));
    step(); step();
    mid(); chk("cont c2 owner", 32'(owner), 32'(OWNER_DATA)); chk("cont c2 ls_done", 32'(ls_done), 1);
    chk("cont c2 ls_r_data", ls_r_data, 32'h5A5A_2000);
    step();
    ls_req = 1'b0;
    mid(); chk("cont c3 owner", 32'(owner), 32'(OWNER_FETCH)); chk("cont c3 addr", mem_addr, 32'h104);
    step(); step();
    mid(); chk("cont c5 if_done", 32'(if_done), 1); chk("cont c5 data", if_r_data, 32'h5A5A_0104);
    step();
    if_req = 1'b0;
    step();

    // Back-to-back stores complete in their request cycle
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_w_data = 32'hDEAD_BEEF; ls_w_mask = 4'hF;
    mid(); chk("st0 w_en", 32'(mem_w_en), 1); chk("st0 done", 32'(ls_done), 1);
    chk("st0 data", mem_w_data, 32'hDEAD_BEEF); chk("st0 addr", mem_addr, 32'h40);
    step();
    ls_addr = 32'h44; ls_w_data = 32'h1234_5678; ls_w_mask = 4'h3;
    mid(); chk("st1 w_en", 32'(mem_w_en), 1); chk("st1 done", 32'(ls_done), 1);
    chk("st1 mask", 32'(mem_w_mask), 32'h3);
    step();
    ls_req = 1'b0; ls_we = 1'b0;
    step();

    // Continuous contention; the previous grant was a store (ls)
    exp_grant = Rr ? '{1, 2, 1, 2} : '{2, 2, 2, 2};
    if_req = 1'b1; if_addr = 32'h200; ls_req = 1'b1; ls_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      mid(); chk("sustained grant", 32'(owner), 32'(exp_grant[i]));
      repeat (L + 1) step();
    end
    if_req = 1'b0; ls_req = 1'b0;
    step();

    // Load whose requester drops req mid-read still completes
    ls_req = 1'b1; ls_addr = 32'h500;
    step();
    ls_req = 1'b0;
    step();
    mid(); chk("drop ls_done", 32'(ls_done), 1); chk("drop ls_r_data", ls_r_data, 32'h5A5A_0500);
    step(); step();

    // Reset mid-read aborts the fetch
    if_req = 1'b1; if_addr = 32'h100;
    step();
    reset_n = 1'b0;
    mid(); chk("rst owner", 32'(owner), 32'(OWNER_NONE)); chk("rst if_done", 32'(if_done), 0);
    step();
    reset_n = 1'b1;
    mid(); chk("rst rearb owner", 32'(owner), 32'(OWNER_FETCH));
    step(); step();
    mid(); chk("rst rearb done", 32'(if_done), 1); chk("rst rearb data", if_r_data, 32'h13);
    step();
    if_req = 1'b0;
    step();

    // After reset the last owner is fetch, so ls wins first contention in both modes
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    if_req = 1'b1; ls_req = 1'b1; ls_addr = 32'h600; if_addr = 32'h700;
    mid(); chk("post-reset grant", 32'(owner), 32'(OWNER_DATA));
    repeat (L + 1) step();
    ls_req = 1'b0;
    repeat (L + 1) step();
    if_req = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch requester and the load/store requester. It owns the port's address, write-data and write-enable lines and tracks the fixed read latency with an internal countdown. Each requester gets a single-cycle `*_done` pulse with its read data. The block sits between the pipeline stages and the memory macro, so the fetch stage talks to it instead of directly to memory.

## Interface
Parameters:
- `XLEN`, 32, data/address width.
- `READ_LATENCY`, 2, cycles from address presentation to valid `mem_r_data`; must be ≥1 (elaboration error otherwise).

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch read request; held until `if_done`.
- `if_addr`  in  XLEN  fetch address; stable while `if_req`.
- `if_done`  out  1  one-cycle pulse; `if_r_data` valid this cycle.
- `if_r_data`  out  XLEN  read data to fetch.
- `ls_req`  in  1  load/store request; held until `ls_done`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  XLEN  data address.
- `ls_w_data`  in  XLEN  store data.
- `ls_w_mask`  in  XLEN/8  byte enables for stores.
- `ls_done`  out  1  one-cycle completion pulse.
- `ls_r_data`  out  XLEN  load data.
- `mem_addr`  out  XLEN  memory address.
- `mem_w_data`  out  XLEN  memory write data.
- `mem_w_en`  out  1  memory write strobe.
- `mem_w_mask`  out  XLEN/8  memory byte enables.
- `mem_r_data`  in  XLEN  memory read data.
- `owner`  out  2  current owner, `arb_owner_t`, for debug and hazard logic.

## Operation
- States: `ARB_IDLE`, `ARB_READ_FETCH`, `ARB_READ_DATA`.
- **IDLE, no requests:** `mem_addr`=0, `mem_w_en`=0, `owner`=`OWNER_NONE`.
- **IDLE, winner selection:** the winner is chosen combinationally and its address drives `mem_addr` in the same cycle (zero-cycle grant).
  - Default policy is fixed priority: ls beats fetch.
- **Store win:**
  - `mem_w_en`=1, with `mem_w_data`/`mem_w_mask` taken from ls.
  - `ls_done`=1 in the same cycle; state stays IDLE.
- **Read win (load or fetch):**
  - Next state is `ARB_READ_DATA` or `ARB_READ_FETCH`.
  - Counter loads `READ_LATENCY-1`.
- **In a READ state:**
  - `mem_addr` continues to be driven from the owner's address.
  - The counter decrements each cycle.
  - When counter==0: assert the owner's `*_done` and route `mem_r_data` to its `*_r_data` (combinational pass-through); next state is IDLE.
- **Non-owner:** its `*_done`=0. `if_r_data`/`ls_r_data` carry `mem_r_data` unconditionally; they are meaningful only with `done`.
- **Requester drops `req` mid-read:** the read still completes and `done` still pulses; the requester ignores it.
- **`req` still high in the cycle after `done`:** treated as a new request.
- **Requests arriving while busy:** they wait. Arbitration happens only in IDLE.
- **Counter width:** `$clog2(READ_LATENCY)` bits, minimum 1. It never wraps, because it is reloaded before use.

## Timing
- **Reset (async assert):** state=IDLE, counter=0, last-owner=fetch. All outputs follow the IDLE/no-request values: `*_done`=0, `mem_w_en`=0, `owner`=NONE.
- **Reset mid-read:** the read is aborted with no `done`. The first arbitration happens in the first cycle after deassertion.
- **Read latency:** with the request seen in IDLE cycle 0, `done` is asserted in cycle `READ_LATENCY`, and IDLE resumes in cycle `READ_LATENCY+1`.
- **Store latency:** 0 cycles (done in the request cycle).
- **Back-to-back reads:** period `READ_LATENCY+1` cycles per read.
- **Back-to-back stores:** one per cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - **Defined:** a 1-bit last-owner flop is updated on every grant. On contention in IDLE, the requester not granted last wins.
  - **Undefined:** fixed ls priority; the flop is not instantiated. Fetch may starve during continuous ls traffic, which is acceptable because the pipeline serialises.

## Structure
- **Shared package:**
  - `arb_owner_t` {`OWNER_NONE`, `OWNER_FETCH`, `OWNER_DATA`}.
  - `arb_state_t` (the three states).
  - `READ_LATENCY` default tied to the existing `mem_read_latency` arch constant.
- **Sub-module:** `mem_arb_latency_counter`, a load/decrement counter with a `zero` flag; everything else stays in one module.

## Test plan
- **Fetch read alone:** `if_req`=1, `if_addr`=0x100 in cycle 0, memory returns 0x00000013.
  - `mem_addr`=0x100 in cycles 0–2.
  - `if_done`=1 in cycle 2 only, with `if_r_data`=0x13.
- **Contention, fixed priority:** `if_req` and `ls_req` (load, 0x2000) together.
  - `owner`=DATA and `ls_done` in cycle 2.
  - Fetch granted in cycle 3, `if_done` in cycle 5.
- **Store:** `ls_we`=1, `ls_addr`=0x40, data 0xDEADBEEF, mask 0xF.
  - `mem_w_en`=1 and `ls_done`=1 in the same cycle.
  - A second store in the next cycle also completes in one cycle.
- **Round-robin (macro defined):** hold both `req` continuously.
  - Grants alternate DATA, FETCH, DATA…
  - Without the macro: DATA every time.
- **Reset mid-read:** pull `reset_n` low in cycle 1 of a fetch read.
  - No `if_done`; `owner`=NONE immediately.
  - After release, a new request completes in the normal `READ_LATENCY`.
